// File: rtl/ethmac_cfg_pkg.sv
// Shared types and constants for the ethmac post-reset configuration sequencer.
// Register offsets are provided for building (address, data) tables.
package ethmac_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR,
        S_RD,
        S_CMP,
        S_NEXT,
        S_DONE,
        S_FAIL
    } cfg_state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ERR     = 2'b10;
    localparam logic [1:0] FC_RDBK    = 2'b11;

    localparam logic [31:0] REG_MODER     = 32'h0000_0000;
    localparam logic [31:0] REG_TX_BD_NUM = 32'h0000_0020;
    localparam logic [31:0] REG_MAC_ADDR0 = 32'h0000_0040;
    localparam logic [31:0] REG_MAC_ADDR1 = 32'h0000_0044;

    // Timer is never narrower than 8 bits, wider only for long timeouts.
    function automatic int timer_width(input int cyc);
        int w;
        w = $clog2(cyc);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/ethmac_cfg_timer.sv
// Saturating access timer: cleared by clr, counts while en, holds at LIMIT.
// expired is high while the count sits at LIMIT.
module ethmac_cfg_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LIM)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LIM);

endmodule

// File: rtl/ethmac_cfg_sequencer.sv
// Walks an (address, data) table and issues one Wishbone write per entry with retry/timeout.
// Define ETHMAC_CFG_READBACK_EN to add a read-back compare after every acked write.
module ethmac_cfg_sequencer
    import ethmac_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [7:0]        tbl_idx_o,
    input  logic [ADDR_W-1:0] tbl_addr_i,
    input  logic [31:0]       tbl_data_i,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [7:0]        fail_idx,
    output logic [1:0]        fail_code
);

    localparam int         TW         = timer_width(TIMEOUT_CYC);
    localparam logic [7:0] LAST_IDX   = 8'(NUM_ENTRIES - 1);
    localparam logic [7:0] RETRY_INIT = 8'(MAX_RETRY);

    cfg_state_t state;
    logic [7:0] idx;
    logic [7:0] retries_left;
    logic       expired;
    logic       tmr_clr;
    logic [1:0] abort_code;

`ifdef ETHMAC_CFG_READBACK_EN
    logic [31:0] rd_data;
`else
    logic rd_unused;
    assign rd_unused = ^wb_dat_i;
`endif

    assign tbl_idx_o = idx;
    assign wb_sel_o  = 4'hF;

    // Restart the timer for every new access, including the read that follows a write.
    assign tmr_clr = (state == S_LOAD) || (wb_stb_o && wb_ack_i);

    ethmac_cfg_timer #(
        .W     (TW),
        .LIMIT (TIMEOUT_CYC - 1)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (wb_stb_o),
        .expired (expired)
    );

    // err wins over a simultaneous ack; timeout only when the slave said nothing.
    always_comb begin
        abort_code = FC_NONE;
        if (state == S_WR || state == S_RD) begin
            if (wb_err_i) begin
                if (retries_left == '0)
                    abort_code = FC_ERR;
            end else if (!wb_ack_i && expired) begin
                abort_code = FC_TIMEOUT;
            end
        end
`ifdef ETHMAC_CFG_READBACK_EN
        if (state == S_CMP && rd_data != wb_dat_o)
            abort_code = FC_RDBK;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            retries_left <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_idx     <= '0;
            fail_code    <= FC_NONE;
`ifdef ETHMAC_CFG_READBACK_EN
            rd_data      <= '0;
`endif
        end else if (abort_code != FC_NONE) begin
            state     <= S_FAIL;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_idx  <= idx;
            fail_code <= abort_code;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state        <= S_LOAD;
                        idx          <= '0;
                        retries_left <= RETRY_INIT;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        fail         <= 1'b0;
                        fail_code    <= FC_NONE;
                    end
                end
                S_LOAD: begin
                    wb_adr_o <= tbl_addr_i;
                    wb_dat_o <= tbl_data_i;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= 1'b1;
                    state    <= S_WR;
                end
                S_WR, S_RD: begin
                    if (wb_err_i) begin
                        // Retry restarts the whole entry, write first.
                        retries_left <= retries_left - 1'b1;
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        wb_we_o      <= 1'b0;
                        state        <= S_LOAD;
                    end else if (wb_ack_i) begin
`ifdef ETHMAC_CFG_READBACK_EN
                        if (state == S_WR) begin
                            wb_we_o <= 1'b0;
                            state   <= S_RD;
                        end else begin
                            rd_data  <= wb_dat_i;
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            state    <= S_CMP;
                        end
`else
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= S_NEXT;
`endif
                    end
                end
                S_CMP: state <= S_NEXT;
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx          <= idx + 1'b1;
                        retries_left <= RETRY_INIT;
                        state        <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
